// File: rtl/ace_instbuf_if.sv
// ace_instbuf_if: fetch-to-decode instruction buffer bus.
//   slave  : buffer side (takes fetch bundle + decode take, drives read slots)
//   master : environment side (fetch/decode)
//   inst_vld_i/inst_i : 8-lane bundle from fetch D0, lane 0 oldest
//   flush_i           : retire flush
//   dec_take_i        : entries decode consumes this cycle (0..4, >4 means 4)
//   dec_vld_o/dec_inst_o : 4 oldest entries, slot 0 oldest
//   instbuf_full_o    : backpressure to fetch
//   instbuf_cnt_o     : current occupancy
interface ace_instbuf_if #(
    parameter int PTR_W = 4
);
    logic [7:0]     inst_vld_i;
    logic [255:0]   inst_i;
    logic           flush_i;
    logic [2:0]     dec_take_i;
    logic [3:0]     dec_vld_o;
    logic [127:0]   dec_inst_o;
    logic           instbuf_full_o;
    logic [PTR_W:0] instbuf_cnt_o;

    modport slave (
        input  inst_vld_i, inst_i, flush_i, dec_take_i,
        output dec_vld_o, dec_inst_o, instbuf_full_o, instbuf_cnt_o
    );

    modport master (
        output inst_vld_i, inst_i, flush_i, dec_take_i,
        input  dec_vld_o, dec_inst_o, instbuf_full_o, instbuf_cnt_o
    );
endinterface

// File: rtl/ace_instbuf.sv
// ace_instbuf: decode stage 0 instruction buffer.
// Compacts the valid lanes of each fetch bundle into a circular queue and
// presents the 4 oldest entries to decode.
//   clock : core clock
//   reset : asynchronous, active-high
//   bus   : ace_instbuf_if.slave (fetch bundle, flush, decode take/read, full, count)
module ace_instbuf #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic         clock,
    input  logic         reset,
    ace_instbuf_if.slave bus
);
    // Full leaves room for a whole 8-lane bundle, so a write can never overflow.
    localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - 8);

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             full;
    logic             wr_en;
    logic [PTR_W:0]   wcnt;
    logic [2:0]       take_req;
    logic [PTR_W:0]   take_ext;
    logic [PTR_W:0]   take;

    assign full  = count_q > FULL_THR;
    assign wr_en = ~full & ~bus.flush_i;

    // Compaction: each valid lane lands at tail plus the number of valid
    // lanes below it, so wcnt doubles as the running write offset.
    always_comb begin
        mem_d = mem_q;
        wcnt  = '0;
        for (int i = 0; i < 8; i++) begin
            if (bus.inst_vld_i[i]) begin
                if (wr_en) begin
                    mem_d[tail_q + wcnt[PTR_W-1:0]] = bus.inst_i[32*i +: 32];
                end
                wcnt = wcnt + (PTR_W+1)'(1);
            end
        end
    end

    always_comb begin
        take_req = (bus.dec_take_i > 3'd4) ? 3'd4 : bus.dec_take_i;
        take_ext = (PTR_W+1)'(take_req);
        take     = (take_ext > count_q) ? count_q : take_ext;
    end

    always_comb begin
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + take[PTR_W-1:0];
            tail_d  = tail_q + (wr_en ? wcnt[PTR_W-1:0] : '0);
            count_d = count_q - take + (wr_en ? wcnt : '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // Read slots come straight from registered state; no write bypass.
    always_comb begin
        logic [PTR_W-1:0] ridx;
        ridx           = '0;
        bus.dec_vld_o  = '0;
        bus.dec_inst_o = '0;
        for (int j = 0; j < 4; j++) begin
            ridx             = head_q + PTR_W'(j);
            bus.dec_vld_o[j] = count_q > (PTR_W+1)'(j);
            bus.dec_inst_o[32*j +: 32] = bus.dec_vld_o[j] ? mem_q[ridx] : 32'h0;
        end
    end

    assign bus.instbuf_full_o = full;
    assign bus.instbuf_cnt_o  = count_q;
endmodule

// File: tb/tb_ace_instbuf.sv
// tb_ace_instbuf: directed vector table plus random traffic for ace_instbuf,
// checked against a queue model of the buffer contents.
module tb_ace_instbuf;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic clock;
    logic reset;

    ace_instbuf_if #(.PTR_W(PTR_W)) bus ();

    ace_instbuf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  vld;
        logic [31:0] base;
        bit          flush;
        logic [2:0]  take;
        int          exp_cnt;
        logic [3:0]  exp_vld;
        bit          exp_full;
    } vec_t;

    vec_t        vecs [$];
    logic [31:0] mq [$];
    int          checks = 0;
    int          errors = 0;

    task automatic add_vec(input logic [7:0] v, input logic [31:0] b, input bit f,
                           input logic [2:0] t, input int c, input logic [3:0] ev,
                           input bit ef);
        vec_t e;
        e.vld = v; e.base = b; e.flush = f; e.take = t;
        e.exp_cnt = c; e.exp_vld = ev; e.exp_full = ef;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bundle, advance the model to the state after the next edge,
    // then return at the following negedge.
    task automatic drive(input logic [7:0] v, input logic [31:0] b, input bit f,
                         input logic [2:0] t);
        bit acc;
        int tk;
        bus.inst_vld_i = v;
        for (int i = 0; i < 8; i++) bus.inst_i[32*i +: 32] = b + 32'(i);
        bus.flush_i    = f;
        bus.dec_take_i = t;
        acc = (mq.size() <= DEPTH - 8) && !f;
        if (f) begin
            mq.delete();
        end else begin
            tk = (int'(t) > 4) ? 4 : int'(t);
            if (tk > mq.size()) tk = mq.size();
            repeat (tk) void'(mq.pop_front());
            if (acc) begin
                for (int i = 0; i < 8; i++)
                    if (v[i]) mq.push_back(b + 32'(i));
            end
        end
        @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        logic [127:0] ei;
        logic [3:0]   ev;
        int           n;
        n  = mq.size();
        ei = '0;
        ev = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < n) begin
                ev[j] = 1'b1;
                ei[32*j +: 32] = mq[j];
            end
        end
        chk({tag, " cnt"},  128'(bus.instbuf_cnt_o), 128'(n));
        chk({tag, " full"}, 128'(bus.instbuf_full_o), 128'(n > DEPTH - 8));
        chk({tag, " vld"},  128'(bus.dec_vld_o), 128'(ev));
        chk({tag, " inst"}, bus.dec_inst_o, ei);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " cnt"},  128'(bus.instbuf_cnt_o), 128'(0));
        chk({tag, " full"}, 128'(bus.instbuf_full_o), 128'(0));
        chk({tag, " vld"},  128'(bus.dec_vld_o), 128'(0));
        chk({tag, " inst"}, bus.dec_inst_o, 128'(0));
    endtask

    initial begin
        logic [7:0]  hv;
        logic [31:0] hb;
        bit          fl;

        reset          = 1'b1;
        bus.inst_vld_i = '0;
        bus.inst_i     = '0;
        bus.flush_i    = 1'b0;
        bus.dec_take_i = '0;

        add_vec(8'hFF, 32'h100, 0, 3'd0,  8, 4'hF, 1);
        vecs[0].exp_full = 0;
        add_vec(8'h07, 32'h200, 0, 3'd0, 11, 4'hF, 1);
        add_vec(8'h0F, 32'h300, 0, 3'd0, 11, 4'hF, 1);
        add_vec(8'h0F, 32'h300, 0, 3'd0, 11, 4'hF, 1);
        add_vec(8'h0F, 32'h300, 0, 3'd0, 11, 4'hF, 1);
        add_vec(8'h0F, 32'h300, 0, 3'd4,  7, 4'hF, 0);
        add_vec(8'h0F, 32'h300, 0, 3'd0, 11, 4'hF, 1);
        add_vec(8'h00, 32'h0,   0, 3'd4,  7, 4'hF, 0);
        add_vec(8'hFF, 32'h400, 0, 3'd0, 15, 4'hF, 1);
        add_vec(8'h00, 32'h0,   0, 3'd7, 11, 4'hF, 1);
        add_vec(8'h00, 32'h0,   0, 3'd4,  7, 4'hF, 0);
        add_vec(8'h00, 32'h0,   0, 3'd4,  3, 4'h7, 0);
        add_vec(8'h00, 32'h0,   0, 3'd4,  0, 4'h0, 0);
        add_vec(8'h00, 32'h0,   0, 3'd7,  0, 4'h0, 0);
        add_vec(8'hA1, 32'h10,  0, 3'd0,  3, 4'h7, 0);
        add_vec(8'h00, 32'h0,   0, 3'd1,  2, 4'h3, 0);
        add_vec(8'h00, 32'h0,   0, 3'd4,  0, 4'h0, 0);
        add_vec(8'hFF, 32'h500, 0, 3'd0,  8, 4'hF, 0);
        add_vec(8'h0F, 32'h600, 0, 3'd0, 12, 4'hF, 1);
        add_vec(8'hFF, 32'h700, 1, 3'd3,  0, 4'h0, 0);
        add_vec(8'hFF, 32'h800, 1, 3'd0,  0, 4'h0, 0);
        add_vec(8'hFF, 32'h900, 0, 3'd0,  8, 4'hF, 0);

        @(negedge clock);
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        check_model("post_reset");

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].vld, vecs[k].base, vecs[k].flush, vecs[k].take);
            chk($sformatf("vec%0d cnt", k),  128'(bus.instbuf_cnt_o), 128'(vecs[k].exp_cnt));
            chk($sformatf("vec%0d vld", k),  128'(bus.dec_vld_o), 128'(vecs[k].exp_vld));
            chk($sformatf("vec%0d full", k), 128'(bus.instbuf_full_o), 128'(vecs[k].exp_full));
            check_model($sformatf("vec%0d", k));
        end

        // Compacted non-prefix mask: slots must show lanes 0, 5, 7 only.
        drive(8'h00, 32'h0, 1, 3'd0);
        drive(8'hA1, 32'h10, 0, 3'd0);
        chk("mask_a1 inst", bus.dec_inst_o, {32'h0, 32'h17, 32'h15, 32'h10});

        // Random traffic; fetch holds its bundle while full.
        hv = 8'h00;
        hb = 32'h0;
        for (int c = 0; c < 100; c++) begin
            if (mq.size() <= DEPTH - 8) begin
                hv = 8'($urandom_range(0, 255));
                hb = 32'h1000 + 32'(c) * 32'h10;
            end
            fl = ($urandom_range(0, 31) == 0);
            drive(hv, hb, fl, 3'($urandom_range(0, 7)));
            check_model($sformatf("rnd%0d", c));
            chk($sformatf("rnd%0d bound", c), 128'(bus.instbuf_cnt_o > 5'(DEPTH)), 128'(0));
        end

        // Asynchronous reset in the middle of traffic.
        drive(8'hFF, 32'h2000, 0, 3'd0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        mq.delete();
        @(negedge clock);
        reset = 1'b0;
        drive(8'h3C, 32'h3000, 0, 3'd0);
        check_model("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
